// File: rtl/ex_redirect_controller_pkg.sv
// Shared types and constants for EX-stage redirect sequencing.
// FSM encodings plus the MIPS opcode/funct values the ID decode uses to build ex_is_*.
package ex_redirect_controller_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } redirState_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/ex_redirect_controller_if.sv
// EX-resolve inputs and IF redirect/flush outputs of the redirect controller.
// master = controller side, slave = pipeline side.
interface ex_redirect_controller_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              ex_valid;
  logic              ex_is_beq;
  logic              ex_is_bne;
  logic              ex_is_j;
  logic              ex_is_jr;
  logic              ex_zero;
  logic [ADDR_W-1:0] incr_pc;
  logic [ADDR_W-1:0] branch_target;
  logic [25:0]       jump_index;
  logic [ADDR_W-1:0] jr_value;
  logic              redir_ready;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              flush_ifid;
  logic              flush_idex;
  logic              addr_err;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    input  ex_valid, ex_is_beq, ex_is_bne, ex_is_j, ex_is_jr, ex_zero,
    input  incr_pc, branch_target, jump_index, jr_value, redir_ready,
    output redir_valid, redir_pc, flush_ifid, flush_idex, addr_err, taken_count
  );

  modport slave (
    output ex_valid, ex_is_beq, ex_is_bne, ex_is_j, ex_is_jr, ex_zero,
    output incr_pc, branch_target, jump_index, jr_value, redir_ready,
    input  redir_valid, redir_pc, flush_ifid, flush_idex, addr_err, taken_count
  );
endinterface

// File: rtl/ex_redirect_controller_redirect_target_mux.sv
// Taken decision and target select for the EX control instruction, priority JR > J > BEQ/BNE.
// Purely combinational, no state and no backpressure.
module redirect_target_mux #(
  parameter int ADDR_W = 32
) (
  input  logic              exValid,
  input  logic              isBeq,
  input  logic              isBne,
  input  logic              isJ,
  input  logic              isJr,
  input  logic              zero,
  input  logic [ADDR_W-1:0] incrPc,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic [25:0]       jumpIndex,
  input  logic [ADDR_W-1:0] jrValue,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  // J only keeps the region bits of PC+4; the rest come from the instr_index.
  logic unusedIncrLow;
  assign unusedIncrLow = ^incrPc[27:0];

  always_comb begin
    taken      = 1'b0;
    target     = '0;
    misaligned = 1'b0;
    if (exValid) begin
      if (isJr) begin
        taken      = 1'b1;
        target     = {jrValue[ADDR_W-1:2], 2'b00};
        misaligned = |jrValue[1:0];
      end else if (isJ) begin
        taken  = 1'b1;
        target = {incrPc[ADDR_W-1:28], jumpIndex, 2'b00};
      end else if ((isBeq && zero) || (isBne && !zero)) begin
        taken  = 1'b1;
        target = branchTarget;
      end
    end
  end

endmodule

// File: rtl/ex_redirect_controller.sv
// Sequences EX-resolved redirects to IF: 1-cycle latency from EX decision to redir_valid.
// redir_valid/redir_pc held until redir_ready; EX inputs ignored while a redirect is in flight.
module ex_redirect_controller
  import ex_redirect_controller_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                      clk,
  input logic                      rst,
  ex_redirect_controller_if.master bus
);

  localparam logic [1:0] DRAIN_LOAD = 2'(FLUSH_CYCLES - 1);

  redirState_t       state;
  logic [1:0]        drainCnt;
  logic              redirValid;
  logic [ADDR_W-1:0] redirPc;
  logic              flushIfid;
  logic              flushIdex;
  logic              addrErr;
  logic [CNT_W-1:0]  takenCount;

  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              misaligned;

  redirect_target_mux #(.ADDR_W(ADDR_W)) u_target_mux (
    .exValid     (bus.ex_valid),
    .isBeq       (bus.ex_is_beq),
    .isBne       (bus.ex_is_bne),
    .isJ         (bus.ex_is_j),
    .isJr        (bus.ex_is_jr),
    .zero        (bus.ex_zero),
    .incrPc      (bus.incr_pc),
    .branchTarget(bus.branch_target),
    .jumpIndex   (bus.jump_index),
    .jrValue     (bus.jr_value),
    .taken       (taken),
    .target      (target),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drainCnt   <= '0;
      redirValid <= 1'b0;
      redirPc    <= '0;
      flushIfid  <= 1'b0;
      flushIdex  <= 1'b0;
      addrErr    <= 1'b0;
      takenCount <= '0;
    end else begin
      addrErr <= 1'b0;
      case (state)
        IDLE: begin
          if (taken) begin
            state      <= REQ;
            redirPc    <= target;
            redirValid <= 1'b1;
            flushIfid  <= 1'b1;
            flushIdex  <= 1'b1;
            addrErr    <= misaligned;
          end
        end
        REQ: begin
          if (bus.redir_ready) begin
            state      <= DRAIN;
            redirValid <= 1'b0;
            flushIdex  <= 1'b0;
            drainCnt   <= DRAIN_LOAD;
            if (takenCount != '1) begin
              takenCount <= takenCount + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // flush_ifid stays high one cycle per FLUSH_CYCLES to kill fetches already in flight
          if (drainCnt == 2'd0) begin
            state     <= IDLE;
            flushIfid <= 1'b0;
          end else begin
            drainCnt <= drainCnt - 2'd1;
          end
        end
        default: begin
          state      <= IDLE;
          redirValid <= 1'b0;
          flushIfid  <= 1'b0;
          flushIdex  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redir_valid = redirValid;
  assign bus.redir_pc    = redirPc;
  assign bus.flush_ifid  = flushIfid;
  assign bus.flush_idex  = flushIdex;
  assign bus.addr_err    = addrErr;
  assign bus.taken_count = takenCount;

endmodule

// File: tb/tb_ex_redirect_controller.sv
// Bench for ex_redirect_controller: two instances (FLUSH_CYCLES=1/CNT_W=16 and FLUSH_CYCLES=3/CNT_W=2)
// driven with identical inputs and compared every cycle against a transaction-level model.
module tb_ex_redirect_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        exValid, isBeq, isBne, isJ, isJr, zero, ready;
  logic [31:0] incrPc, branchTarget, jrValue;
  logic [25:0] jumpIndex;

  ex_redirect_controller_if #(.ADDR_W(32), .CNT_W(16)) bus0 ();
  ex_redirect_controller_if #(.ADDR_W(32), .CNT_W(2))  bus1 ();

  ex_redirect_controller #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ex_redirect_controller #(.ADDR_W(32), .FLUSH_CYCLES(3), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.ex_valid = exValid;      assign bus1.ex_valid = exValid;
  assign bus0.ex_is_beq = isBeq;       assign bus1.ex_is_beq = isBeq;
  assign bus0.ex_is_bne = isBne;       assign bus1.ex_is_bne = isBne;
  assign bus0.ex_is_j = isJ;           assign bus1.ex_is_j = isJ;
  assign bus0.ex_is_jr = isJr;         assign bus1.ex_is_jr = isJr;
  assign bus0.ex_zero = zero;          assign bus1.ex_zero = zero;
  assign bus0.incr_pc = incrPc;        assign bus1.incr_pc = incrPc;
  assign bus0.branch_target = branchTarget; assign bus1.branch_target = branchTarget;
  assign bus0.jump_index = jumpIndex;  assign bus1.jump_index = jumpIndex;
  assign bus0.jr_value = jrValue;      assign bus1.jr_value = jrValue;
  assign bus0.redir_ready = ready;     assign bus1.redir_ready = ready;

  int passed = 0;
  int total  = 0;

  // Model: a redirect is either awaiting acceptance, or draining for some cycles, or absent.
  bit          mWait[2];
  int          mDrain[2];
  logic [31:0] mPc[2];
  bit          mErr[2];
  int          mCount[2];
  int          flushCfg[2] = '{1, 3};
  int          cntMax[2]   = '{65535, 3};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    exValid = 0; isBeq = 0; isBne = 0; isJ = 0; isJr = 0; zero = 0; ready = 0;
    incrPc = 0; branchTarget = 0; jrValue = 0; jumpIndex = 0;
  endtask

  task automatic checkAll();
    logic [63:0] oV[2], oPc[2], oIf[2], oId[2], oErr[2], oCnt[2];
    oV[0] = 64'(bus0.redir_valid); oV[1] = 64'(bus1.redir_valid);
    oPc[0] = 64'(bus0.redir_pc);   oPc[1] = 64'(bus1.redir_pc);
    oIf[0] = 64'(bus0.flush_ifid); oIf[1] = 64'(bus1.flush_ifid);
    oId[0] = 64'(bus0.flush_idex); oId[1] = 64'(bus1.flush_idex);
    oErr[0] = 64'(bus0.addr_err);  oErr[1] = 64'(bus1.addr_err);
    oCnt[0] = 64'(bus0.taken_count); oCnt[1] = 64'(bus1.taken_count);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d redir_valid", d), oV[d], 64'(mWait[d]));
      check($sformatf("d%0d redir_pc", d), oPc[d], 64'(mPc[d]));
      check($sformatf("d%0d flush_ifid", d), oIf[d], 64'(mWait[d] || mDrain[d] > 0));
      check($sformatf("d%0d flush_idex", d), oId[d], 64'(mWait[d]));
      check($sformatf("d%0d addr_err", d), oErr[d], 64'(mErr[d]));
      check($sformatf("d%0d taken_count", d), oCnt[d], 64'(mCount[d]));
    end
  endtask

  task automatic tick();
    bit          tk, mis;
    logic [31:0] tg;
    bit          nWait[2];
    int          nDrain[2];
    logic [31:0] nPc[2];
    bit          nErr[2];
    int          nCount[2];
    tk = 0; mis = 0; tg = 0;
    if (exValid) begin
      if (isJr) begin
        tk = 1; tg = jrValue & ~32'h3; mis = (jrValue % 4) != 0;
      end else if (isJ) begin
        tk = 1; tg = (incrPc & 32'hF000_0000) | (32'(jumpIndex) * 4);
      end else if ((isBeq && zero) || (isBne && !zero)) begin
        tk = 1; tg = branchTarget;
      end
    end
    for (int d = 0; d < 2; d++) begin
      nWait[d] = mWait[d]; nDrain[d] = mDrain[d]; nPc[d] = mPc[d]; nCount[d] = mCount[d]; nErr[d] = 0;
      if (rst) begin
        nWait[d] = 0; nDrain[d] = 0; nPc[d] = 0; nCount[d] = 0;
      end else if (mWait[d]) begin
        if (ready) begin
          nWait[d] = 0; nDrain[d] = flushCfg[d];
          nCount[d] = (mCount[d] < cntMax[d]) ? mCount[d] + 1 : mCount[d];
        end
      end else if (mDrain[d] > 0) begin
        nDrain[d] = mDrain[d] - 1;
      end else if (tk) begin
        nWait[d] = 1; nPc[d] = tg; nErr[d] = mis;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mWait[d] = nWait[d]; mDrain[d] = nDrain[d]; mPc[d] = nPc[d]; mErr[d] = nErr[d]; mCount[d] = nCount[d];
    end
    checkAll();
  endtask

  task automatic waitIdle();
    clearIn();
    ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (!mWait[0] && !mWait[1] && mDrain[0] == 0 && mDrain[1] == 0) break;
      tick();
    end
    clearIn();
  endtask

  initial begin
    clearIn();
    rst = 1;
    tick();
    tick();
    check("reset redir_valid", 64'(bus0.redir_valid), 64'd0);
    check("reset taken_count", 64'(bus0.taken_count), 64'd0);
    rst = 0;
    tick();

    // BEQ taken, accepted immediately
    exValid = 1; isBeq = 1; zero = 1; branchTarget = 32'h0040_0020; ready = 1;
    tick();
    check("beq redir_pc", 64'(bus0.redir_pc), 64'h0040_0020);
    check("beq flush_idex", 64'(bus0.flush_idex), 64'd1);
    clearIn(); ready = 1;
    tick();
    check("beq drain flush_ifid", 64'(bus0.flush_ifid), 64'd1);
    check("beq drain redir_valid", 64'(bus0.redir_valid), 64'd0);
    check("beq count", 64'(bus0.taken_count), 64'd1);
    tick();
    check("beq idle flush_ifid", 64'(bus0.flush_ifid), 64'd0);
    waitIdle();

    // Not-taken BNE and BEQ
    exValid = 1; isBne = 1; zero = 1; branchTarget = 32'h1234_5678;
    tick();
    check("bne nt redir_valid", 64'(bus0.redir_valid), 64'd0);
    isBne = 0; isBeq = 1; zero = 0;
    tick();
    check("beq nt flush_ifid", 64'(bus0.flush_ifid), 64'd0);
    check("nt count", 64'(bus0.taken_count), 64'd1);
    waitIdle();

    // J held off by redir_ready for three cycles
    exValid = 1; isJ = 1; incrPc = 32'h9000_0004; jumpIndex = 26'h100;
    tick();
    check("j redir_pc", 64'(bus0.redir_pc), 64'h9000_0400);
    clearIn();
    repeat (3) begin
      tick();
      check("j hold valid", 64'(bus0.redir_valid), 64'd1);
      check("j hold pc", 64'(bus0.redir_pc), 64'h9000_0400);
    end
    ready = 1;
    tick();
    check("j count", 64'(bus0.taken_count), 64'd2);
    waitIdle();

    // JR beats BEQ, misaligned; branches during REQ/DRAIN ignored
    exValid = 1; isJr = 1; isBeq = 1; zero = 1; jrValue = 32'h0000_1003; branchTarget = 32'h0040_0020;
    tick();
    check("jr redir_pc", 64'(bus0.redir_pc), 64'h0000_1000);
    check("jr addr_err", 64'(bus0.addr_err), 64'd1);
    isJr = 0; branchTarget = 32'h0BAD_0000;
    tick();
    check("jr addr_err pulse", 64'(bus0.addr_err), 64'd0);
    ready = 1;
    tick();
    ready = 0;
    tick();
    check("jr ignored branch", 64'(bus0.redir_valid), 64'd0);
    check("jr pc kept", 64'(bus0.redir_pc), 64'h0000_1000);
    waitIdle();

    // Reset mid-redirect, then a fresh J
    exValid = 1; isJ = 1; incrPc = 32'h9000_0004; jumpIndex = 26'h5;
    tick();
    clearIn(); rst = 1;
    tick();
    check("rst redir_valid", 64'(bus0.redir_valid), 64'd0);
    check("rst redir_pc", 64'(bus0.redir_pc), 64'd0);
    check("rst count", 64'(bus0.taken_count), 64'd0);
    rst = 0;
    exValid = 1; isJ = 1; incrPc = 32'h1000_0000; jumpIndex = 26'h40;
    tick();
    check("post-rst j pc", 64'(bus0.redir_pc), 64'h1000_0100);
    waitIdle();

    // Saturation of the 2-bit counter
    repeat (4) begin
      exValid = 1; isJ = 1; incrPc = $urandom; jumpIndex = 26'($urandom); ready = 1;
      tick();
      waitIdle();
    end
    check("sat count d1", 64'(bus1.taken_count), 64'd3);
    check("unsat count d0", 64'(bus0.taken_count), 64'd5);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      exValid      = ($urandom_range(0, 3) != 0);
      isBeq        = ($urandom_range(0, 3) == 0);
      isBne        = ($urandom_range(0, 3) == 0);
      isJ          = ($urandom_range(0, 5) == 0);
      isJr         = ($urandom_range(0, 5) == 0);
      zero         = $urandom_range(0, 1);
      ready        = $urandom_range(0, 1);
      incrPc       = $urandom;
      branchTarget = $urandom;
      jrValue      = $urandom;
      jumpIndex    = 26'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
